ps2_key_decoder: RTL and testbench

//  Upstream feeder for the keyboard matrix: receives raw PS/2 clock/data lines

---
 rtl/ps2_key_decoder.sv | 250 +++++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard receiver. Synchronises and de-glitches the raw
// PS/2 clock/data lines, deframes 11-bit frames (start, 8 data LSB first, odd
// parity, stop) and folds E0/F0/E1 prefixes into an 11-bit key event word:
// [7:0] scancode, [8] extended, [9] pressed, [10] toggles once per event.
// Optional build macro PS2_REPEAT_FILTER_EN suppresses typematic repeat makes.
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // One filter step: {new filtered value, new run counter}. The filtered
    // value follows the sample only after FILTER_LEN consecutive differing samples.
    function automatic logic [FW:0] filt_step(input logic smp, input logic filt,
                                              input logic [FW-1:0] cnt);
        logic [FW:0] res;
        if (smp == filt) begin
            res = {filt, {FW{1'b0}}};
        end else if (cnt == FW'(FILTER_LEN - 1)) begin
            res = {smp, {FW{1'b0}}};
        end else begin
            res = {filt, cnt + FW'(1)};
        end
        return res;
    endfunction

    // Bytes dropped when no prefix is pending (BAT, ack, resend, echo, overrun).
    function automatic logic is_discard(input logic [7:0] b);
        logic res;
        case (b)
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: res = 1'b1;
            default:                                  res = 1'b0;
        endcase
        return res;
    endfunction

    logic [1:0]    clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
    logic [FW-1:0] clk_cnt_q, clk_cnt_d, data_cnt_q, data_cnt_d;
    logic          clk_filt_q, clk_filt_d, data_filt_q, data_filt_d;
    logic          clk_prev_q, clk_prev_d;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d, rx_byte_q, rx_byte_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_valid_q, byte_valid_d;
    logic          ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic [2:0]    skip_cnt_q, skip_cnt_d;
    logic [10:0]   key_q, key_d;
    logic          frame_err_q, frame_err_d;
    logic          strobe_s, err_s, suppress_s;
`ifdef PS2_REPEAT_FILTER_EN
    logic [8:0]    trk_q, trk_d;
    logic          trk_vld_q, trk_vld_d;
`endif

    // Next-state logic: input conditioning, frame FSM, timeout, prefix folding.
    always_comb begin
        clk_sync_d   = {clk_sync_q[0], ps2_clk};
        data_sync_d  = {data_sync_q[0], ps2_data};
        {clk_filt_d, clk_cnt_d}   = filt_step(clk_sync_q[1], clk_filt_q, clk_cnt_q);
        {data_filt_d, data_cnt_d} = filt_step(data_sync_q[1], data_filt_q, data_cnt_q);
        clk_prev_d   = clk_filt_q;
        strobe_s     = clk_prev_q & ~clk_filt_q;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_byte_d    = rx_byte_q;
        parity_d     = parity_q;
        to_cnt_d     = to_cnt_q;
        byte_valid_d = 1'b0;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        skip_cnt_d   = skip_cnt_q;
        key_d        = key_q;
        frame_err_d  = 1'b0;
        err_s        = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
        trk_d        = trk_q;
        trk_vld_d    = trk_vld_q;
        suppress_s   = ~brk_pend_q & trk_vld_q & (trk_q == {ext_pend_q, rx_byte_q});
`else
        suppress_s   = 1'b0;
`endif

        // Frame FSM advances only on the filtered clock's falling edge.
        if (strobe_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (!data_filt_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_filt_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    parity_d = data_filt_q;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (data_filt_q && (^{shift_q, parity_q})) begin
                        byte_valid_d = 1'b1;
                        rx_byte_d    = shift_q;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end

        // Inter-edge watchdog; a strobe on the terminal cycle takes priority.
        if (strobe_s || (state_q == ST_IDLE)) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            to_cnt_d = '0;
            state_d  = ST_IDLE;
            err_s    = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        // Byte interpretation; a frame error wipes all pending prefix context.
        if (err_s) begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
            skip_cnt_d  = 3'd0;
`ifdef PS2_REPEAT_FILTER_EN
            trk_vld_d   = 1'b0;
`endif
        end else if (byte_valid_q) begin
            if (skip_cnt_q != 3'd0) begin
                skip_cnt_d = skip_cnt_q - 3'd1;
            end else if (rx_byte_q == 8'hE1) begin
                skip_cnt_d = 3'd7;
            end else if (rx_byte_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (rx_byte_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else if (!ext_pend_q && !brk_pend_q && is_discard(rx_byte_q)) begin
                skip_cnt_d = skip_cnt_q;
            end else begin
                if (!suppress_s) begin
                    key_d = {~key_q[10], ~brk_pend_q, ext_pend_q, rx_byte_q};
                end else begin
                    key_d = key_q;
                end
`ifdef PS2_REPEAT_FILTER_EN
                if (brk_pend_q) begin
                    trk_vld_d = 1'b0;
                end else begin
                    trk_vld_d = 1'b1;
                    trk_d     = {ext_pend_q, rx_byte_q};
                end
`endif
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end else begin
            frame_err_d = 1'b0;
        end
    end

    // State and output registers; reset aborts any frame silently.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q   <= 2'b11;
            data_sync_q  <= 2'b11;
            clk_cnt_q    <= '0;
            data_cnt_q   <= '0;
            clk_filt_q   <= 1'b1;
            data_filt_q  <= 1'b1;
            clk_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            rx_byte_q    <= 8'h00;
            parity_q     <= 1'b0;
            to_cnt_q     <= '0;
            byte_valid_q <= 1'b0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            skip_cnt_q   <= 3'd0;
            key_q        <= 11'h000;
            frame_err_q  <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
            trk_q        <= 9'h000;
            trk_vld_q    <= 1'b0;
`endif
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            clk_cnt_q    <= clk_cnt_d;
            data_cnt_q   <= data_cnt_d;
            clk_filt_q   <= clk_filt_d;
            data_filt_q  <= data_filt_d;
            clk_prev_q   <= clk_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_byte_q    <= rx_byte_d;
            parity_q     <= parity_d;
            to_cnt_q     <= to_cnt_d;
            byte_valid_q <= byte_valid_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            skip_cnt_q   <= skip_cnt_d;
            key_q        <= key_d;
            frame_err_q  <= frame_err_d;
`ifdef PS2_REPEAT_FILTER_EN
            trk_q        <= trk_d;
            trk_vld_q    <= trk_vld_d;
`endif
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench for ps2_key_decoder: drives PS/2 frames bit by bit and compares the
// event word and error pulses against a byte-level reference model.
module tb_ps2_key_decoder;

    localparam int FILT = 8;
    localparam int TOUT = 2000;
    localparam int HALF = 20;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TOUT)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk(ps2_clk),
        .ps2_data(ps2_data), .ps2_key(ps2_key), .frame_err(frame_err)
    );

    always #5 clk_sys = ~clk_sys;

`ifdef PS2_REPEAT_FILTER_EN
    localparam bit RF_EN = 1'b1;
`else
    localparam bit RF_EN = 1'b0;
`endif

    int n_vec = 0;
    int n_fail = 0;

    // Observed event / error counts, sampled on the falling clock edge.
    int          ev_seen = 0;
    int          err_seen = 0;
    int          err_wide = 0;
    logic [10:0] prev_key = 11'h000;
    logic        prev_err = 1'b0;

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev_key <= 11'h000;
            prev_err <= 1'b0;
        end else begin
            if (ps2_key !== prev_key) ev_seen <= ev_seen + 1;
            if (frame_err === 1'b1) err_seen <= err_seen + 1;
            if (frame_err === 1'b1 && prev_err === 1'b1) err_wide <= err_wide + 1;
            prev_key <= ps2_key;
            prev_err <= frame_err;
        end
    end

    // Reference model state: what the decoder should have emitted so far.
    logic [10:0] m_key = 11'h000;
    bit          m_ext = 1'b0, m_brk = 1'b0;
    int          m_skip = 0;
    bit          m_trk_vld = 1'b0;
    logic [8:0]  m_trk = 9'h000;
    int          m_ev = 0;
    int          m_err = 0;

    task automatic model_reset();
        m_key = 11'h000; m_ext = 1'b0; m_brk = 1'b0; m_skip = 0; m_trk_vld = 1'b0;
    endtask

    task automatic model_err();
        m_err++; m_ext = 1'b0; m_brk = 1'b0; m_skip = 0; m_trk_vld = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit pressed;
        if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (!m_ext && !m_brk &&
                     (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'h00 || b == 8'hFF)) begin
            // acknowledgement / self-test bytes carry no key
        end else begin
            pressed = !m_brk;
            if (RF_EN && pressed && m_trk_vld && m_trk == {m_ext, b}) begin
                // repeat make swallowed
            end else begin
                m_key = {~m_key[10], pressed, m_ext, b};
                m_ev++;
            end
            if (RF_EN) begin
                m_trk_vld = pressed;
                m_trk = {m_ext, b};
            end
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop bit.
    task automatic send_frame(input logic [7:0] b, input int kind);
        logic par;
        par = ~(^b);
        if (kind == 1) par = ~par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit((kind == 2) ? 1'b0 : 1'b1);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        if (kind == 0) model_byte(b);
        else model_err();
    endtask

    task automatic send_partial(input int nbits);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wait_cyc(3);
        #1;
        n_vec++;
        if (ps2_key !== 11'h000) begin n_fail++; $display("FAIL reset_key: got %h want 000", ps2_key); end
        n_vec++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", frame_err); end
        reset_n = 1'b1;
        model_reset();
        wait_cyc(HALF);
    endtask

    task automatic test_make();
        int ev0;
        ev0 = ev_seen;
        send_frame(8'h1C, 0);
        n_vec++;
        if (ps2_key !== 11'h61C) begin n_fail++; $display("FAIL make_1c: got %h want 61c", ps2_key); end
        n_vec++;
        if (ev_seen - ev0 !== 1) begin n_fail++; $display("FAIL make_once: got %0d events want 1", ev_seen - ev0); end
    endtask

    task automatic test_ext_break();
        int ev0;
        ev0 = ev_seen;
        send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
        n_vec++;
        if (ps2_key[9:0] !== 10'h175) begin n_fail++; $display("FAIL ext_break_bits: got %h want 175", ps2_key[9:0]); end
        n_vec++;
        if (ps2_key !== m_key) begin n_fail++; $display("FAIL ext_break_key: got %h want %h", ps2_key, m_key); end
        n_vec++;
        if (ev_seen - ev0 !== 1) begin n_fail++; $display("FAIL ext_break_once: got %0d want 1", ev_seen - ev0); end
    endtask

    task automatic test_parity_err();
        logic [10:0] k0;
        int e0;
        k0 = ps2_key; e0 = err_seen;
        send_frame(8'hE0, 0);
        send_frame(8'h1C, 1);
        n_vec++;
        if (err_seen - e0 !== 1) begin n_fail++; $display("FAIL parity_err_pulse: got %0d want 1", err_seen - e0); end
        n_vec++;
        if (ps2_key !== k0) begin n_fail++; $display("FAIL parity_key_hold: got %h want %h", ps2_key, k0); end
        send_frame(8'h1C, 0);
        n_vec++;
        if (ps2_key[8] !== 1'b0 || ps2_key !== m_key) begin
            n_fail++; $display("FAIL parity_prefix_clear: got %h want %h", ps2_key, m_key);
        end
        send_frame(8'h4B, 2);
        n_vec++;
        if (err_seen - e0 !== 2) begin n_fail++; $display("FAIL stop_err_pulse: got %0d want 2", err_seen - e0); end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_seen;
        send_partial(5);
        wait_cyc(TOUT - 100);
        n_vec++;
        if (err_seen !== e0) begin n_fail++; $display("FAIL timeout_early: got %0d errs want 0", err_seen - e0); end
        wait_cyc(300);
        model_err();
        n_vec++;
        if (err_seen - e0 !== 1) begin n_fail++; $display("FAIL timeout_pulse: got %0d want 1", err_seen - e0); end
        send_frame(8'h29, 0);
        n_vec++;
        if (ps2_key !== m_key || ps2_key[7:0] !== 8'h29) begin
            n_fail++; $display("FAIL timeout_recover: got %h want %h", ps2_key, m_key);
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [9];
        int ev0;
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h16};
        ev0 = ev_seen;
        foreach (seq[i]) send_frame(seq[i], 0);
        n_vec++;
        if (ev_seen - ev0 !== 1) begin n_fail++; $display("FAIL pause_events: got %0d want 1", ev_seen - ev0); end
        n_vec++;
        if (ps2_key !== m_key || ps2_key[9:0] !== 10'h216) begin
            n_fail++; $display("FAIL pause_key: got %h want %h", ps2_key, m_key);
        end
    endtask

    task automatic test_repeat();
        int ev0;
        ev0 = ev_seen;
        for (int i = 0; i < 3; i++) send_frame(8'h1C, 0);
        send_frame(8'hF0, 0); send_frame(8'h1C, 0);
        n_vec++;
        if (ev_seen - ev0 !== (RF_EN ? 2 : 4)) begin
            n_fail++; $display("FAIL repeat_events: got %0d want %0d", ev_seen - ev0, RF_EN ? 2 : 4);
        end
        n_vec++;
        if (ps2_key !== m_key) begin n_fail++; $display("FAIL repeat_key: got %h want %h", ps2_key, m_key); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(8'h01, 8'h7F));
            send_bit(1'b0);
            for (int j = 0; j < 8; j++) send_bit(b[j]);
            send_bit(~(^b));
            send_bit(1'b1);
            model_byte(b);
        end
        ps2_data = 1'b1;
        wait_cyc(HALF);
        n_vec++;
        if (ps2_key !== m_key) begin n_fail++; $display("FAIL b2b_key: got %h want %h", ps2_key, m_key); end
        n_vec++;
        if (ev_seen !== m_ev) begin n_fail++; $display("FAIL b2b_events: got %0d want %0d", ev_seen, m_ev); end
    endtask

    task automatic test_reset_midframe();
        int e0;
        e0 = err_seen;
        send_partial(4);
        reset_n = 1'b0;
        wait_cyc(5);
        reset_n = 1'b1;
        model_reset();
        wait_cyc(2 * TOUT);
        n_vec++;
        if (ps2_key !== 11'h000) begin n_fail++; $display("FAIL midreset_key: got %h want 000", ps2_key); end
        n_vec++;
        if (err_seen !== e0) begin n_fail++; $display("FAIL midreset_err: got %0d errs want 0", err_seen - e0); end
        send_frame(8'h1C, 0);
        n_vec++;
        if (ps2_key !== 11'h61C) begin n_fail++; $display("FAIL midreset_next: got %h want 61c", ps2_key); end
    endtask

    task automatic test_random();
        logic [7:0] pool [14];
        logic [7:0] b;
        int k;
        pool = '{8'h1C, 8'h1C, 8'h29, 8'h75, 8'hE0, 8'hF0, 8'hE0, 8'hF0,
                 8'hE1, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'h16};
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 17);
            if (k < 14) b = pool[k];
            else b = 8'($urandom_range(0, 255));
            k = $urandom_range(0, 9);
            send_frame(b, (k == 0) ? 1 : ((k == 1) ? 2 : 0));
            n_vec++;
            if (ps2_key !== m_key) begin n_fail++; $display("FAIL rand_key[%0d]: byte %h got %h want %h", i, b, ps2_key, m_key); end
            n_vec++;
            if (ev_seen !== m_ev) begin n_fail++; $display("FAIL rand_events[%0d]: got %0d want %0d", i, ev_seen, m_ev); end
            n_vec++;
            if (err_seen !== m_err) begin n_fail++; $display("FAIL rand_errs[%0d]: got %0d want %0d", i, err_seen, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_make();
        test_ext_break();
        test_parity_err();
        test_timeout();
        test_pause();
        test_repeat();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        n_vec++;
        if (err_wide !== 0) begin n_fail++; $display("FAIL err_width: got %0d long pulses want 0", err_wide); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
